// File: rtl/rv_reg_file_mp_if.sv
// Decode/writeback-side bundle for the parametrised register file: write port, two read ports, clear control, status.
// Master drives indices, data and CLEAR; the slave (register file) returns read data, BUSY and WERR.
interface rv_reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              WRITE;
    logic [ADDR_W-1:0] WADDR;
    logic [DATA_W-1:0] WDATA;
    logic [ADDR_W-1:0] RADDR1;
    logic [ADDR_W-1:0] RADDR2;
    logic [DATA_W-1:0] RDATA1;
    logic [DATA_W-1:0] RDATA2;
    logic              CLEAR;
    logic              BUSY;
    logic              WERR;

    modport master (
        output WRITE, WADDR, WDATA, RADDR1, RADDR2, CLEAR,
        input  RDATA1, RDATA2, BUSY, WERR
    );

    modport slave (
        input  WRITE, WADDR, WDATA, RADDR1, RADDR2, CLEAR,
        output RDATA1, RDATA2, BUSY, WERR
    );
endinterface

// File: rtl/rv_reg_file_mp.sv
// Parametrised register file: 2 combinational read ports (optional x0 / write bypass), 1 write port, sequential clear sweep.
// Reads are 0-cycle, writes land at the edge; no backpressure: writes during a sweep or with CLEAR are dropped and flagged on WERR.
module rv_reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    rv_reg_file_mp_if.slave   rf
);
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEARING
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              werr_q, werr_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              x0_hit_w;
    logic              byp_en;
    logic [DATA_W-1:0] rdata1, rdata2;

    assign x0_hit_w = (ZERO_REG != 0) && (rf.WADDR == '0);
    assign byp_en   = (BYPASS != 0) && (state_q == IDLE) && rf.WRITE && !rf.CLEAR;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        werr_d  = 1'b0;
        regs_d  = regs_q;
        case (state_q)
            IDLE: begin
                // CLEAR wins over a coincident write, which is then reported as rejected.
                if (rf.CLEAR) begin
                    state_d = CLEARING;
                    cnt_d   = '0;
                    werr_d  = rf.WRITE;
                end else if (rf.WRITE && !x0_hit_w) begin
                    regs_d[rf.WADDR] = rf.WDATA;
                end
            end
            CLEARING: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                werr_d        = rf.WRITE;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CLEARING);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            werr_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            werr_q  <= werr_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        if ((ZERO_REG != 0) && (rf.RADDR1 == '0)) begin
            rdata1 = '0;
        end else if (byp_en && (rf.WADDR == rf.RADDR1)) begin
            rdata1 = rf.WDATA;
        end else begin
            rdata1 = regs_q[rf.RADDR1];
        end

        if ((ZERO_REG != 0) && (rf.RADDR2 == '0)) begin
            rdata2 = '0;
        end else if (byp_en && (rf.WADDR == rf.RADDR2)) begin
            rdata2 = rf.WDATA;
        end else begin
            rdata2 = regs_q[rf.RADDR2];
        end
    end

    assign rf.RDATA1 = rdata1;
    assign rf.RDATA2 = rdata2;
    assign rf.BUSY   = busy_q;
    assign rf.WERR   = werr_q;
endmodule
